// File: rtl/prescale_rate_controller.sv
// rtl/prescale_rate_controller.sv - fast/slow CLOCK_50 prescaler with boundary-aligned rate changes; optional hold port via DIVIDER_HOLD_EN
module prescale_rate_controller #(
  parameter int unsigned FAST_HALF = 50000,
  parameter int unsigned SLOW_HALF = 5000000,
  parameter int unsigned CNT_W     = 27
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic rate_req,
  input  logic rate_sel,
  output logic scaledClock,
  output logic tick,
  output logic cur_sel,
  output logic busy,
  output logic rate_ack
`ifdef DIVIDER_HOLD_EN
  ,
  input  logic hold
`endif
);

  localparam logic [CNT_W-1:0] FAST_LIM = CNT_W'(FAST_HALF - 1);
  localparam logic [CNT_W-1:0] SLOW_LIM = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t           state;
  logic             pend_sel;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] limit;
  logic             run;
  logic             at_limit;
  logic             fall_edge;

`ifdef DIVIDER_HOLD_EN
  assign run = ~hold;
`else
  assign run = 1'b1;
`endif

  // The limit follows cur_sel, which only changes together with counter<=0,
  // so the counter can never be stranded above a smaller new limit.
  assign limit     = cur_sel ? SLOW_LIM : FAST_LIM;
  assign at_limit  = run && (counter == limit);
  assign fall_edge = at_limit && scaledClock;

  // Divider: count to the half-period limit, then toggle the scaled clock and emit a tick.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      counter     <= '0;
      scaledClock <= 1'b0;
      tick        <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (at_limit) begin
        counter     <= '0;
        scaledClock <= ~scaledClock;
        tick        <= 1'b1;
      end else if (run) begin
        counter <= counter + CNT_ONE;
      end
    end
  end

  // Rate FSM: latch a differing request, commit it on the next falling boundary of scaledClock.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      pend_sel <= 1'b0;
      cur_sel  <= 1'b0;
      busy     <= 1'b0;
      rate_ack <= 1'b0;
    end else begin
      rate_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (rate_req) begin
            if (rate_sel != cur_sel) begin
              pend_sel <= rate_sel;
              busy     <= 1'b1;
              state    <= PENDING;
            end else begin
              rate_ack <= 1'b1;
            end
          end
        end
        PENDING: begin
          if (fall_edge) begin
            cur_sel  <= pend_sel;
            rate_ack <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prescale_rate_controller.sv
// tb/tb_prescale_rate_controller.sv - scoreboard bench for prescale_rate_controller
module tb_prescale_rate_controller;

  localparam int FAST = 4;
  localparam int SLOW = 10;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  logic rate_req = 1'b0;
  logic rate_sel = 1'b0;
  logic hold_i   = 1'b0;
  logic scaledClock, tick, cur_sel, busy, rate_ack;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int c0     = 0;

  typedef struct {
    int cyc;
    bit tk;
    bit ak;
  } ev_t;

  ev_t q[$];
  ev_t ev;

  // reference model state: time of next toggle instead of a counter
  bit m_level, m_rate, m_pend, m_pend_sel;
  int m_next;

  always #5 CLOCK_50 = ~CLOCK_50;

  prescale_rate_controller #(
    .FAST_HALF(FAST),
    .SLOW_HALF(SLOW),
    .CNT_W(27)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn(resetn),
    .rate_req(rate_req),
    .rate_sel(rate_sel),
    .scaledClock(scaledClock),
    .tick(tick),
    .cur_sel(cur_sel),
    .busy(busy),
    .rate_ack(rate_ack)
`ifdef DIVIDER_HOLD_EN
    ,
    .hold(hold_i)
`endif
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (rel cycle %0d)", name, got, exp, cyc - c0);
    end
  endtask

  task automatic model_clear();
    m_level = 0;
    m_rate = 0;
    m_pend = 0;
    m_pend_sel = 0;
    q.delete();
  endtask

  task automatic model_step();
    bit tk, ak, pend0, rate0;
    tk = 0;
    ak = 0;
    pend0 = m_pend;
    rate0 = m_rate;
    if (hold_i) begin
      m_next = m_next + 1;
    end else if (cyc == m_next) begin
      tk = 1;
      if (m_level && pend0) begin
        m_rate = m_pend_sel;
        m_pend = 0;
        ak = 1;
      end
      m_level = !m_level;
      m_next = cyc + (m_rate ? SLOW : FAST);
    end
    if (!pend0 && rate_req) begin
      if (rate_sel != rate0) begin
        m_pend = 1;
        m_pend_sel = rate_sel;
      end else begin
        ak = 1;
      end
    end
    if (tk || ak) q.push_back('{cyc: cyc, tk: tk, ak: ak});
  endtask

  // model advances on every active edge using the same inputs the DUT samples
  always @(posedge CLOCK_50) begin
    cyc = cyc + 1;
    if (!resetn) begin
      model_clear();
      c0 = cyc;
      m_next = cyc + FAST;
    end else begin
      model_step();
    end
  end

  // asynchronous reset drops everything, including any pending request
  always @(negedge resetn) model_clear();

  // monitor: compare levels every cycle, pop the scoreboard whenever an event is due or seen
  always @(negedge CLOCK_50) begin
    if (resetn) begin
      chk("scaledClock", scaledClock, m_level);
      chk("cur_sel", cur_sel, m_rate);
      chk("busy", busy, m_pend);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev = q.pop_front();
        chk("tick", tick, ev.tk);
        chk("rate_ack", rate_ack, ev.ak);
      end else if (tick || rate_ack) begin
        chk("unexpected_tick", tick, 0);
        chk("unexpected_ack", rate_ack, 0);
      end
    end
  end

  task automatic wait_rel(input int n);
    int guard;
    guard = 0;
    while ((cyc - c0) != n) begin
      @(negedge CLOCK_50);
      guard++;
      if (guard > 2000) begin
        checks++;
        errors++;
        $display("FAIL wait_rel timeout waiting for rel cycle %0d", n);
        return;
      end
    end
  endtask

  task automatic do_reset(input bit sync_first);
    if (sync_first) @(negedge CLOCK_50);
    #2;
    resetn = 1'b0;
    rate_req = 1'b0;
    hold_i = 1'b0;
    #1;
    chk("rst_scaledClock", scaledClock, 0);
    chk("rst_tick", tick, 0);
    chk("rst_cur_sel", cur_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rate_ack", rate_ack, 0);
    repeat (2) @(negedge CLOCK_50);
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    do_reset(1);

    // slow request while scaledClock is high, plus an ignored request while busy
    wait_rel(4);
    chk("first_rise", scaledClock, 1);
    chk("first_tick", tick, 1);
    wait_rel(5);
    rate_req = 1'b1;
    rate_sel = 1'b1;
    wait_rel(6);
    chk("busy_rise", busy, 1);
    rate_sel = 1'b0;
    wait_rel(7);
    rate_req = 1'b0;
    wait_rel(8);
    chk("apply_ack", rate_ack, 1);
    chk("apply_cur_sel", cur_sel, 1);
    chk("apply_busy", busy, 0);
    chk("apply_fall", scaledClock, 0);
    wait_rel(9);
    chk("single_ack", rate_ack, 0);
    wait_rel(17);
    chk("slow_low", scaledClock, 0);
    wait_rel(18);
    chk("slow_rise", scaledClock, 1);

    // same-rate request at slow rate
    wait_rel(20);
    rate_req = 1'b1;
    rate_sel = 1'b1;
    wait_rel(21);
    rate_req = 1'b0;
    chk("same_ack", rate_ack, 1);
    chk("same_busy", busy, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge CLOCK_50);
      rate_req = ($urandom_range(0, 5) == 0);
      rate_sel = 1'($urandom_range(0, 1));
`ifdef DIVIDER_HOLD_EN
      hold_i = ($urandom_range(0, 7) == 0);
`endif
    end
    @(negedge CLOCK_50);
    rate_req = 1'b0;
    hold_i = 1'b0;

    // reset while a request is pending
    g = 0;
    while (m_pend && g < 100) begin
      @(negedge CLOCK_50);
      g++;
    end
    rate_req = 1'b1;
    rate_sel = !m_rate;
    @(negedge CLOCK_50);
    rate_req = 1'b0;
    chk("busy_before_reset", busy, 1);
    do_reset(0);

    // same-rate request at fast rate leaves the pattern untouched
    wait_rel(1);
    rate_req = 1'b1;
    rate_sel = 1'b0;
    wait_rel(2);
    rate_req = 1'b0;
    chk("fast_same_ack", rate_ack, 1);
    chk("fast_same_busy", busy, 0);
    wait_rel(8);
    chk("post_reset_fall_tick", tick, 1);
    wait_rel(12);
    chk("post_reset_rise", scaledClock, 1);

`ifdef DIVIDER_HOLD_EN
    do_reset(1);
    wait_rel(2);
    hold_i = 1'b1;
    wait_rel(12);
    hold_i = 1'b0;
    wait_rel(13);
    chk("hold_still_low", scaledClock, 0);
    wait_rel(14);
    chk("hold_rise", scaledClock, 1);
    chk("hold_rise_tick", tick, 1);
`endif

    repeat (5) @(negedge CLOCK_50);
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescale_rate_controller.md
# prescale_rate_controller

Clock-enable generator and rate scheduler for the calculator's timing path. It divides CLOCK_50 by one of two prescale values, fast or slow, and produces a square scaled clock plus a one-cycle tick. It accepts rate-change requests over a req/ack handshake and applies each change only at a scaled-clock period boundary, so the scaled clock never has a truncated period. Display and key-scan logic consume the tick and arbitrate their rate needs through this block.

## Interface
- FAST_HALF, 50000: CLOCK_50 cycles per scaled half-period in fast mode; ≥2.
- SLOW_HALF, 5000000: CLOCK_50 cycles per scaled half-period in slow mode; ≥2.
- CNT_W, 27: counter width; must hold max(FAST_HALF, SLOW_HALF)-1.
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  reset; asynchronous and active-low.
- rate_req  in  1  request strobe; sampled only while busy=0.
- rate_sel  in  1  requested rate, 0=fast, 1=slow; sampled with rate_req.
- scaledClock  out  1  divided square clock.
- tick  out  1  one-cycle pulse on every scaledClock toggle.
- cur_sel  out  1  rate currently in effect.
- busy  out  1  request pending; new requests ignored.
- rate_ack  out  1  one-cycle pulse when the pending request has been applied.
- hold  in  1  freezes the divider; present only with DIVIDER_HOLD_EN.

## Operation
- Limit L = FAST_HALF if cur_sel=0, else SLOW_HALF.
- Counter: counter<=counter+1 each cycle. When counter==L-1:
  - counter<=0
  - scaledClock<=~scaledClock
  - tick<=1
- tick is 0 on every other cycle.
- The FSM has two states, IDLE and PENDING.
  - IDLE, rate_req=1 and rate_sel!=cur_sel: latch pend_sel<=rate_sel, go to PENDING, busy<=1.
  - IDLE, rate_req=1 and rate_sel==cur_sel: rate_ack<=1 on the next edge, remain in IDLE, no state change.
  - PENDING, counter==L-1 and scaledClock==1 (falling boundary of scaledClock): cur_sel<=pend_sel, counter<=0, rate_ack<=1, busy<=0, go to IDLE. The next half-period uses the new L.
  - PENDING, otherwise: hold. rate_req is ignored and no ack is produced for ignored requests.
- A request accepted on the same edge as a falling boundary is not applied at that boundary; it waits for the next falling boundary.
- Arithmetic is unsigned with no wrap: the counter never exceeds L-1. A change of L takes effect only together with counter<=0.

## Timing
- Reset values: scaledClock=0, tick=0, cur_sel=0, busy=0, rate_ack=0, counter=0, state=IDLE, pend_sel=0.
- Asserting resetn low mid-operation clears everything immediately. Any pending request is dropped with no ack.
- First rising scaledClock edge occurs FAST_HALF cycles after resetn deasserts. tick is high in the same cycle that scaledClock changes.
- busy rises 1 cycle after an accepted rate_req.
- Request-to-ack latency is 1 to 2·L_old+1 cycles.
- rate_ack, cur_sel change, and busy fall all occur in the same cycle.
- Outputs are registered, with no combinational path from any input to any output.

## Configuration
- DIVIDER_HOLD_EN defined:
  - The hold port exists.
  - While hold=1, the counter and scaledClock freeze and tick=0.
  - The FSM still accepts requests, but boundaries do not occur, so a PENDING request waits.
  - On hold release, counting resumes from the frozen value.
- DIVIDER_HOLD_EN undefined: the hold port is absent and the divider runs freely.

## Test plan
Run all scenarios with FAST_HALF=4 and SLOW_HALF=10.
- Reset release, no requests: scaledClock rises at cycle 4, falls at 8, rises at 12; tick is high exactly at cycles 4, 8, 12; cur_sel=0.
- rate_req=1 with rate_sel=1 at cycle 5, while scaledClock is high: busy=1 at 6; at cycle 8, scaledClock falls, rate_ack=1, cur_sel=1, busy=0; the next rise is at cycle 18.
- Same-rate request, rate_sel=0 while cur_sel=0: rate_ack pulses on the next cycle, busy stays 0, the scaledClock pattern is unchanged.
- While busy, a second rate_req with rate_sel=0: it is ignored; only one rate_ack is seen; cur_sel ends at 1.
- resetn pulsed low while PENDING: all outputs return to reset values immediately; no rate_ack appears afterwards.
- DIVIDER_HOLD_EN, hold=1 for cycles 2–11: the first scaledClock rise moves to cycle 14; tick=0 throughout the hold.
